// File: rtl/sine_tone_sequencer.sv
// sine_tone_sequencer: plays a table of (incr, dur) tones into a sine generator's en/incr inputs.
// Define SEQ_GAP_EN to insert one gen_en=0 cycle at every entry boundary.
module sine_tone_sequencer #(
  parameter int D_WIDTH   = 8,
  parameter int DUR_WIDTH = 16,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [D_WIDTH-1:0]         wr_incr,
  input  logic [DUR_WIDTH-1:0]       wr_dur,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       loop,
  input  logic                       start,
  input  logic                       stop,
  output logic                       gen_en,
  output logic [D_WIDTH-1:0]         gen_incr,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       busy,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef SEQ_GAP_EN
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic {IDLE, PLAY} state_t;
`endif
  state_t               state, state_n;
  logic [D_WIDTH-1:0]   incr_t [DEPTH];
  logic [DUR_WIDTH-1:0] dur_t  [DEPTH];
  logic [AW-1:0]        idx, idx_n, nxt;
  logic [DUR_WIDTH-1:0] cnt, cnt_n;
  logic [LW-1:0]        eff_len, len_n;
  logic                 loop_q, loop_n, last;
  logic [D_WIDTH-1:0]   incr_n;
  logic                 en_n, busy_n, done_n;
  function automatic logic [DUR_WIDTH-1:0] ld(input logic [DUR_WIDTH-1:0] d);
    return (d == '0) ? DUR_WIDTH'(1) : d;
  endfunction
  assign step_idx = idx;
  assign last = {1'b0, idx} == eff_len - LW'(1);
  assign nxt = last ? '0 : idx + AW'(1);
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    len_n   = eff_len;
    loop_n  = loop_q;
    incr_n  = gen_incr;
    en_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    if (stop) state_n = IDLE;
    else if (state == IDLE) begin
      if (start && len != '0) begin
        state_n = PLAY;
        idx_n   = '0;
        cnt_n   = ld(dur_t[0]);
        len_n   = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
        loop_n  = loop;
        incr_n  = incr_t[0];
        en_n    = 1'b1;
        busy_n  = 1'b1;
      end
    end
`ifdef SEQ_GAP_EN
    else if (state == GAP) begin
      state_n = PLAY;
      en_n    = 1'b1;
      busy_n  = 1'b1;
    end
`endif
    else if (cnt != DUR_WIDTH'(1)) begin
      cnt_n  = cnt - DUR_WIDTH'(1);
      en_n   = 1'b1;
      busy_n = 1'b1;
    end
    else if (last && !loop_q) begin
      state_n = IDLE;
      done_n  = 1'b1;
    end
    else begin
      idx_n  = nxt;
      cnt_n  = ld(dur_t[nxt]);
      incr_n = incr_t[nxt];
      busy_n = 1'b1;
`ifdef SEQ_GAP_EN
      state_n = GAP;
`else
      en_n = 1'b1;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      eff_len  <= '0;
      loop_q   <= 1'b0;
      gen_incr <= '0;
      gen_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        incr_t[i] <= '0;
        dur_t[i]  <= '0;
      end
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      eff_len  <= len_n;
      loop_q   <= loop_n;
      gen_incr <= incr_n;
      gen_en   <= en_n;
      busy     <= busy_n;
      done     <= done_n;
      if (wr_en && !busy) begin
        incr_t[wr_addr] <= wr_incr;
        dur_t[wr_addr]  <= wr_dur;
      end
    end
  end
endmodule

// File: doc/sine_tone_sequencer.md
Name: sine_tone_sequencer

Overview:
Sequences the sine generator through a programmable list of tones. Each tone is a (phase increment, duration) pair held in a small register table. The block drives the generator's enable and increment inputs cycle by cycle, so the generator plays a melody or frequency sweep without CPU involvement. It sits directly upstream of the sine generator's en/incr ports.

Parameters:
D_WIDTH, 8, width of phase increment (matches sine generator incr/dout width)
DUR_WIDTH, 16, width of per-entry duration in clock cycles
DEPTH, 8, number of table entries (power of two, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
wr_en  input  1  table write strobe
wr_addr  input  $clog2(DEPTH)  table entry to write
wr_incr  input  D_WIDTH  increment value to write
wr_dur  input  DUR_WIDTH  duration value to write
len  input  $clog2(DEPTH)+1  number of entries to play, sampled at start
loop  input  1  repeat sequence, sampled at start
start  input  1  begin playback (level, acted on in IDLE only)
stop  input  1  abort playback
gen_en  output  1  to sine generator en
gen_incr  output  D_WIDTH  to sine generator incr
step_idx  output  $clog2(DEPTH)  entry currently playing
busy  output  1  high whenever not IDLE
done  output  1  one-cycle pulse on natural completion

Behaviour:
- All outputs registered. Reset values: gen_en=0, gen_incr=0, step_idx=0, busy=0, done=0, all table entries 0, FSM=IDLE, loop/len latches 0.
- Table write: on a clock edge with wr_en=1 and busy=0, table[wr_addr] <= {wr_incr, wr_dur}. Writes while busy=1 are discarded (table stays stable during playback).
- FSM states: IDLE, PLAY (plus GAP when SEQ_GAP_EN is defined).
- IDLE: start=1, stop=0, len!=0 -> latch eff_len=min(len,DEPTH) and loop. Set idx=0 and dur_cnt=max(table[0].dur,1). Go to PLAY. At the next edge gen_en=1, gen_incr=table[0].incr, busy=1. Latency from start sampled to gen_en high: 1 cycle.
- start with len=0 in IDLE: ignored, no done pulse.
- start while busy: ignored.
- PLAY: gen_en=1, gen_incr=table[idx].incr. Each entry holds for exactly max(dur,1) cycles; dur=0 is treated as 1. dur_cnt decrements each cycle. When dur_cnt==1 the entry ends:
  - idx < eff_len-1: idx+1, reload dur_cnt from the next entry; no bubble, gen_incr changes on the following cycle.
  - idx == eff_len-1 and loop latched: idx wraps to 0, reload, continue.
  - idx == eff_len-1 and not loop: go IDLE; gen_en=0, busy=0, done=1 for one cycle. gen_incr holds its last value; step_idx holds the last index.
- stop=1 in any state: IDLE at the next edge, gen_en=0, busy=0, no done pulse. stop and start in the same cycle: stop wins.
- step_idx mirrors idx, registered alongside gen_incr.
- dur_cnt is DUR_WIDTH bits, unsigned; no overflow possible since it only decrements from a loaded value.
- Reset asserted mid-playback: immediate return to reset values, table cleared.

Optional Feature:
SEQ_GAP_EN
- Defined: FSM adds a GAP state. At every entry boundary, including the loop wrap, there is exactly one cycle with gen_en=0 before the next entry. In that cycle gen_incr and step_idx already show the next entry. The final entry of a non-looping run goes straight to IDLE with no gap. stop during GAP -> IDLE.
- Undefined: entries play back-to-back with gen_en continuously high; no GAP state exists.

Test Plan:
- Reset, then write table[0]={incr=4,dur=3} and table[1]={incr=9,dur=2}; start with len=2, loop=0 -> gen_en high for 5 cycles, gen_incr=4,4,4,9,9; done pulses for 1 cycle after; busy falls with done.
- Same table, loop=1; run 12 cycles then pulse stop -> incr pattern 4,4,4,9,9 repeats, step_idx wraps 1->0; gen_en=0 the cycle after stop; done never pulses.
- Entry with dur=0 and incr=7, len=1 -> gen_en high exactly 1 cycle with incr=7, then done.
- Write table[0] incr=20 while busy -> table unchanged; next run still plays the original incr=4. Also: start with len=0 -> nothing happens; start with len=15 on DEPTH=8 -> plays 8 entries.
- start and stop asserted together in IDLE -> stays IDLE, busy=0. Drive rst=0 mid-PLAY -> gen_en=0 and busy=0 immediately (asynchronous), table reads back 0 on next run.
- With SEQ_GAP_EN, same 2-entry table, loop=0 -> gen_en pattern 1,1,1,0,1,1 then done; gen_incr=9 during the gap cycle.
